// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with add/sub in one cycle and iterative mul/div.
// Result and z/n/c/w flags are registered and held until the next completion.
module alu_seq #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic [N-1:0] o,
  output logic         z,
  output logic         n,
  output logic         c,
  output logic         w
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t st, st_nx;

  logic [CW-1:0]  cnt;
  logic           op_div;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [N-1:0]   bq;
  logic [N-1:0]   quo;
  logic [N-1:0]   rem;

  logic           accept;
  logic           last;
  logic [N:0]     sum;
  logic [N:0]     dif;
  logic [2*N-1:0] prod_nx;
  logic [N:0]     rtry;
  logic [N:0]     rsub;
  logic           qbit;
  logic [N-1:0]   rem_nx;
  logic [N-1:0]   quo_nx;

  logic           wr_en;
  logic [N-1:0]   res_o;
  logic           res_c;
  logic           res_w;

  assign accept = in_valid && ready;
  assign last   = (cnt == CW'(N - 1));

  // Full-width arithmetic: carry, borrow and product high half stay visible
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    dif     = {1'b0, a} - {1'b0, b};
    prod_nx = mplier[0] ? prod + mcand : prod;
    rtry    = {rem, quo[N-1]};
    rsub    = rtry - {1'b0, bq};
    qbit    = !rsub[N];
    rem_nx  = qbit ? rsub[N-1:0] : rtry[N-1:0];
    quo_nx  = {quo[N-2:0], qbit};
  end

  // Select the value and flags written at a completion edge
  always_comb begin
    wr_en = 1'b0;
    res_o = '0;
    res_c = 1'b0;
    res_w = 1'b0;
    if (st == RUN && last) begin
      wr_en = 1'b1;
      if (op_div) begin
        res_o = (bq == '0) ? '1 : quo_nx;
        res_w = (bq == '0);
      end else begin
        res_o = prod_nx[N-1:0];
        res_c = |prod_nx[2*N-1:N];
      end
    end else if (accept && !op[1]) begin
      wr_en = 1'b1;
      unique case (1'b1)
        op[0]: begin
          res_o = dif[N-1:0];
          res_c = dif[N];
          res_w = (a[N-1] != b[N-1]) &&
                  (dif[N-1] != a[N-1]);
        end
        default: begin
          res_o = sum[N-1:0];
          res_c = sum[N];
          res_w = (a[N-1] == b[N-1]) &&
                  (sum[N-1] != a[N-1]);
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) st <= IDLE;
    else       st <= st_nx;
  end

  // Next-state logic
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE, DONE: begin
        if (accept) st_nx = op[1] ? RUN : DONE;
        else        st_nx = IDLE;
      end
      RUN:     st_nx = last ? DONE : RUN;
      default: st_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready     = (st == IDLE) || (st == DONE);
    out_valid = (st == DONE);
  end

  // Operand load, iteration datapath and result/flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      op_div <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      bq     <= '0;
      quo    <= '0;
      rem    <= '0;
      o      <= '0;
      z      <= 1'b0;
      n      <= 1'b0;
      c      <= 1'b0;
      w      <= 1'b0;
    end else begin
      if (accept && op[1]) begin
        cnt    <= '0;
        op_div <= op[0];
        prod   <= '0;
        mcand  <= {{N{1'b0}}, a};
        mplier <= b;
        bq     <= b;
        quo    <= a;
        rem    <= '0;
      end else if (st == RUN) begin
        cnt    <= cnt + CW'(1);
        prod   <= prod_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        quo    <= quo_nx;
        rem    <= rem_nx;
      end
      if (wr_en) begin
        o <= res_o;
        z <= (res_o == '0);
        n <= res_o[N-1];
        c <= res_c;
        w <= res_w;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq (N=8)
// against an arithmetic reference model.
module tb_alu_seq;

  localparam int N = 8;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         ready;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic [N-1:0] o;
  logic         z;
  logic         n;
  logic         c;
  logic         w;

  int errors = 0;
  int checks = 0;

  alu_seq #(.N(N)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .ready(ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .o(o),
    .z(z),
    .n(n),
    .c(c),
    .w(w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {o,z,n,c,w} from integer arithmetic
  function automatic logic [11:0] ref_model(
    input logic [1:0] op_i,
    input logic [7:0] a_i,
    input logic [7:0] b_i
  );
    int ua, ub, sa, sb, r, s;
    logic [7:0] ov;
    logic cf, wf;
    ua = int'(a_i);
    ub = int'(b_i);
    sa = int'($signed(a_i));
    sb = int'($signed(b_i));
    cf = 1'b0;
    wf = 1'b0;
    case (op_i)
      2'd0: begin
        r = ua + ub;
        ov = r[7:0];
        cf = (r > 255);
        s = sa + sb;
        wf = (s > 127) || (s < -128);
      end
      2'd1: begin
        r = ua - ub;
        ov = r[7:0];
        cf = (ua < ub);
        s = sa - sb;
        wf = (s > 127) || (s < -128);
      end
      2'd2: begin
        r = ua * ub;
        ov = r[7:0];
        cf = (r > 255);
      end
      default: begin
        if (ub == 0) begin
          ov = 8'hFF;
          wf = 1'b1;
        end else begin
          r = ua / ub;
          ov = r[7:0];
        end
      end
    endcase
    return {ov, (ov == 8'h00), ov[7], cf, wf};
  endfunction

  task automatic run_op(
    input  logic [1:0]  op_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [11:0] got,
    output int          lat
  );
    @(negedge clock);
    in_valid = 1'b1;
    op = op_i;
    a = a_i;
    b = b_i;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    got = {o, z, n, c, w};
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    op = 2'd0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({o, z, n, c, w} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outs: got %h want 000", {o, z, n, c, w});
    end
    checks++;
    if (out_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: got ov=%b rdy=%b want 0 1", out_valid, ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_arith(input logic [1:0] op_i, input int n_rand,
                            input logic [7:0] d0a, input logic [7:0] d0b,
                            input logic [7:0] d1a, input logic [7:0] d1b,
                            input int want_lat);
    logic [11:0] got, exp;
    logic [7:0] ta, tb;
    int lat;
    for (int i = 0; i < n_rand + 2; i++) begin
      if (i == 0) begin
        ta = d0a;
        tb = d0b;
      end else if (i == 1) begin
        ta = d1a;
        tb = d1b;
      end else begin
        ta = 8'($urandom);
        tb = 8'($urandom);
        if (op_i == 2'd3 && i % 5 == 0) tb = 8'h00;
      end
      exp = ref_model(op_i, ta, tb);
      run_op(op_i, ta, tb, got, lat);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL op%0d_result %h,%h: got %h want %h",
                 op_i, ta, tb, got, exp);
      end
      checks++;
      if (lat != want_lat) begin
        errors++;
        $display("FAIL op%0d_latency: got %0d want %0d", op_i, lat, want_lat);
      end
    end
  endtask

  task automatic test_div_hold;
    int lat, leaked, pulses;
    logic [11:0] exp;
    exp = ref_model(2'd3, 8'hC8, 8'h07);
    @(negedge clock);
    in_valid = 1'b1;
    op = 2'd3;
    a = 8'hC8;
    b = 8'h07;
    @(negedge clock);
    lat = 1;
    leaked = 0;
    while (!out_valid && lat < 20) begin
      if (ready) leaked++;
      a = 8'($urandom);
      b = 8'($urandom);
      op = 2'($urandom);
      @(negedge clock);
      lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (lat != 9 || leaked != 0) begin
      errors++;
      $display("FAIL div_hold_timing: got lat=%0d rdy_hi=%0d want 9 0",
               lat, leaked);
    end
    checks++;
    if ({o, z, n, c, w} !== exp) begin
      errors++;
      $display("FAIL div_hold_result: got %h want %h", {o, z, n, c, w}, exp);
    end
    pulses = 0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL div_hold_extra: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] xa[3];
    logic [7:0] xb[3];
    logic [7:0] ma, mb, pa, pb;
    int lat;
    for (int i = 0; i < 3; i++) begin
      xa[i] = 8'($urandom);
      xb[i] = 8'($urandom);
    end
    @(negedge clock);
    in_valid = 1'b1;
    op = 2'd0;
    a = xa[0];
    b = xb[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 ||
          {o, z, n, c, w} !== ref_model(2'd0, xa[i], xb[i])) begin
        errors++;
        $display("FAIL b2b_add%0d: got ov=%b %h want 1 %h", i, out_valid,
                 {o, z, n, c, w}, ref_model(2'd0, xa[i], xb[i]));
      end
      if (i < 2) begin
        a = xa[i+1];
        b = xb[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got ov=%b want 0", out_valid);
    end
    ma = 8'($urandom);
    mb = 8'($urandom);
    pa = 8'($urandom);
    pb = 8'($urandom);
    @(negedge clock);
    in_valid = 1'b1;
    op = 2'd2;
    a = ma;
    b = mb;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checks++;
    if (lat != 9 || {o, z, n, c, w} !== ref_model(2'd2, ma, mb)) begin
      errors++;
      $display("FAIL b2b_mul: got lat=%0d %h want 9 %h", lat,
               {o, z, n, c, w}, ref_model(2'd2, ma, mb));
    end
    in_valid = 1'b1;
    op = 2'd0;
    a = pa;
    b = pb;
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 ||
        {o, z, n, c, w} !== ref_model(2'd0, pa, pb)) begin
      errors++;
      $display("FAIL b2b_mul_add: got ov=%b %h want 1 %h", out_valid,
               {o, z, n, c, w}, ref_model(2'd0, pa, pb));
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_mul_add_end: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_abort;
    logic [11:0] got;
    int lat, pulses;
    run_op(2'd0, 8'h01, 8'h01, got, lat);
    @(negedge clock);
    in_valid = 1'b1;
    op = 2'd2;
    a = 8'h35;
    b = 8'h17;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b1;
    op = 2'd0;
    a = 8'h11;
    b = 8'h22;
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({o, z, n, c, w} !== 12'h000 || out_valid !== 1'b0 ||
        ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: got %h ov=%b rdy=%b want 000 0 1",
               {o, z, n, c, w}, out_valid, ready);
    end
    pulses = 0;
    repeat (15) begin
      @(negedge clock);
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_pulse: got %0d pulses want 0", pulses);
    end
    run_op(2'd0, 8'h03, 8'h04, got, lat);
    checks++;
    if (got !== 12'h070 || lat != 1) begin
      errors++;
      $display("FAIL abort_add: got %h lat=%0d want 070 1", got, lat);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    test_reset();
    test_arith(2'd0, 12, 8'h7F, 8'h01, 8'hFF, 8'h01, 1);
    test_arith(2'd1, 12, 8'h05, 8'h07, 8'h80, 8'h01, 1);
    test_arith(2'd2, 8, 8'h10, 8'h10, 8'h0C, 8'h0B, 9);
    test_arith(2'd3, 8, 8'hC8, 8'h07, 8'h2A, 8'h00, 9);
    test_div_hold();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the datapath. It extends the single-cycle add/subtract unit with multiply and divide and fully defined z/n/c/w flags. Operands are taken through a valid/ready handshake. Add/sub complete in one cycle; mul/div run iteratively for N cycles. The result and flags are registered and held until the next completion.

## Interface
- N, 32, operand/result width in bits (N >= 4)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands and op are valid this cycle
- ready  out  1  unit can accept; combinational from state
- op  in  2  00 add, 01 sub, 10 mul (unsigned, low N bits), 11 div (unsigned quotient)
- a  in  N  first operand
- b  in  N  second operand
- out_valid  out  1  one-cycle pulse: o/flags updated this cycle
- o  out  N  result
- z  out  1  o == 0
- n  out  1  o[N-1]
- c  out  1  carry / borrow / multiply overflow (see Operation)
- w  out  1  signed overflow / divide-by-zero (see Operation)

## Operation
- States: IDLE, RUN, DONE.
- ready = (state == IDLE || state == DONE).
- Accept: rising edge with in_valid && ready. a, b and op are latched. in_valid with ready low is ignored; no queueing.
- Accept of add/sub: the result is computed and registered at the accept edge; state -> DONE.
- Accept of mul/div: operands are loaded, iteration counter = 0, state -> RUN.
- RUN: one iteration per cycle.
  - mul: shift-add, 2N-bit product.
  - div: restoring, N-bit quotient and remainder.
  - After iteration N-1, o and flags are written; state -> DONE.
- DONE: out_valid = 1 for exactly this cycle. Next state is DONE again if a new accept occurs (add/sub), RUN (mul/div accept), else IDLE.
- o and flags hold their value outside result-write edges.
- Flags are computed at result write; z and n always derive from o.
  - add: c = carry out of bit N-1; w = (a[N-1]==b[N-1]) && (o[N-1]!=a[N-1]).
  - sub (a-b): c = borrow (a < b unsigned); w = (a[N-1]!=b[N-1]) && (o[N-1]!=a[N-1]).
  - mul: o = low N bits of product; c = (high N bits != 0); w = 0.
  - div: o = floor(a/b); c = 0; w = 0.
  - div with b == 0: o = all ones, w = 1, c = 0; still takes the full N-cycle latency.
- All arithmetic is modulo 2^N on o. No internal signal may truncate the 2N-bit product or the N+1-bit add/sub sum before the flags are derived.

## Timing
- Reset (any state, including mid-RUN): state = IDLE, counter = 0, o = 0, z = 0, n = 0, c = 0, w = 0, out_valid = 0. ready = 1 in the cycle after the reset edge. An in-flight operation is discarded, with no out_valid.
- reset has priority over in_valid at the same edge.
- add/sub latency: accept at edge k -> out_valid high in cycle k+1.
- mul/div latency: accept at edge k -> out_valid high in cycle k+N+1. ready is low for cycles k+1 .. k+N.
- Throughput:
  - add/sub: one per cycle (accept in DONE is allowed).
  - mul/div: one per N+1 cycles.
- Back-to-back: an accept in the DONE cycle does not suppress that cycle's out_valid. The new result overwrites o at its own completion edge.
- No output backpressure: out_valid is not held and a result is never stalled.

## Test plan
- N=8: add 7F+01 -> out_valid 1 cycle after accept; o=80, n=1, w=1, c=0, z=0. Then add FF+01 -> o=00, z=1, c=1, w=0.
- N=8: sub 05-07 -> o=FE, n=1, c=1, w=0. Then sub 80-01 -> o=7F, w=1, c=0.
- N=8: mul 10*10 -> out_valid exactly 9 cycles after accept; o=00, z=1, c=1. Then mul 0C*0B -> o=84, c=0, n=1.
- N=8: div C8/07 -> o=1C, latency 9. Then div 2A/00 -> o=FF, w=1, n=1, c=0, latency 9. in_valid held high during RUN is ignored: ready=0, one result only.
- Back-to-back add streams: 3 consecutive accepts -> 3 consecutive out_valid pulses, each o correct. An add accepted in a mul's DONE cycle -> mul result pulse, then add result pulse the next cycle.
- Assert reset during cycle 4 of a mul -> next cycle state IDLE, all outputs 0, ready=1, no out_valid ever for the aborted op. A following add 03+04 -> o=07 with latency 1.
